// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, PC steering codes and the per-stage record used by the hazard controller.
// Pure definitions; no logic and no timing of its own.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_ALU   = 2'b01;
   localparam logic [1:0] PC_HOLD  = 2'b10;

   typedef enum logic {ST_BOOT, ST_RUN} hz_state_t;

   typedef struct packed {
      logic       valid;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       regwr;
      logic       uses_rs1;
      logic       uses_rs2;
      logic       is_branch;
      logic       is_jump;
   } stage_rec_t;

   // regwr already excludes rd==x0, so x0 can never produce a forward.
   function automatic logic fwd_hit(input stage_rec_t wb, input logic [4:0] r);
      return wb.valid & wb.regwr & (wb.rd == r);
   endfunction

endpackage

// File: rtl/hz_decode.sv
// Hazard-relevant decode of one instruction word: register fields and read/write/control class.
// Purely combinational.
module hz_decode
   import riscv_pkg::*;
(
   input  logic [31:0] i_inst,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic        o_regwr,
   output logic        o_uses_rs1,
   output logic        o_uses_rs2,
   output logic        o_is_branch,
   output logic        o_is_jump
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];
   assign o_rd  = i_inst[11:7];
   assign o_rs1 = i_inst[19:15];
   assign o_rs2 = i_inst[24:20];

   always_comb begin
      o_regwr     = 1'b0;
      o_uses_rs1  = 1'b0;
      o_uses_rs2  = 1'b0;
      o_is_branch = 1'b0;
      o_is_jump   = 1'b0;
      case (w_opc)
         OPC_LUI, OPC_AUIPC: o_regwr = 1'b1;
         OPC_JAL: begin
            o_regwr   = 1'b1;
            o_is_jump = 1'b1;
         end
         OPC_JALR: begin
            o_regwr    = 1'b1;
            o_uses_rs1 = 1'b1;
            o_is_jump  = 1'b1;
         end
         OPC_BRANCH: begin
            o_uses_rs1  = 1'b1;
            o_uses_rs2  = 1'b1;
            o_is_branch = 1'b1;
         end
         OPC_LOAD, OPC_OPIMM: begin
            o_regwr    = 1'b1;
            o_uses_rs1 = 1'b1;
         end
         OPC_STORE: begin
            o_uses_rs1 = 1'b1;
            o_uses_rs2 = 1'b1;
         end
         OPC_OP: begin
            o_regwr    = 1'b1;
            o_uses_rs1 = 1'b1;
            o_uses_rs2 = 1'b1;
         end
         OPC_SYSTEM: o_uses_rs1 = (w_f3 == 3'b001);
         default: ;
      endcase
      if (o_rd == 5'd0) o_regwr = 1'b0;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Fetch steering, bubble injection and WB->IF/D/EX forwarding for the 3-stage pipeline, plus perf counters.
// Controls are combinational from the EX/WB records; stall_req freezes fetch unless a redirect overrides it.
module pipe_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter int          CNT_W    = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_id,
   input  logic             BrEq,
   input  logic             BrLt,
   input  logic             stall_req,
   input  logic             cnt_clr,
   output logic [1:0]       PCSel,
   output logic             InstSel,
   output logic             BrUn,
   output logic             FA_1,
   output logic             FB_1,
   output logic             FA_2,
   output logic             FB_2,
   output logic             ex_valid,
   output logic             wb_valid,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   hz_state_t        r_state;
   stage_rec_t       r_ex;
   stage_rec_t       r_wb;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;

   stage_rec_t w_id;
   logic [4:0] w_rd, w_rs1, w_rs2;
   logic       w_regwr, w_uses_rs1, w_uses_rs2, w_is_branch, w_is_jump;
   logic       w_run;
   logic       w_take;
   logic       w_redirect;

   hz_decode u_dec (
      .i_inst      (inst_id),
      .o_rd        (w_rd),
      .o_rs1       (w_rs1),
      .o_rs2       (w_rs2),
      .o_regwr     (w_regwr),
      .o_uses_rs1  (w_uses_rs1),
      .o_uses_rs2  (w_uses_rs2),
      .o_is_branch (w_is_branch),
      .o_is_jump   (w_is_jump)
   );

   // Reset is folded in combinationally so controls are safe before the first reset edge.
   assign w_run    = rst & (r_state == ST_RUN);
   assign ex_valid = w_run & r_ex.valid;
   assign wb_valid = w_run & r_wb.valid;

   always_comb begin
      w_take = 1'b0;
      if (r_ex.is_jump) begin
         w_take = 1'b1;
      end else if (r_ex.is_branch) begin
         case (r_ex.funct3)
            F3_BEQ:           w_take = BrEq;
            F3_BNE:           w_take = ~BrEq;
            F3_BLT, F3_BLTU:  w_take = BrLt;
            F3_BGE, F3_BGEU:  w_take = ~BrLt;
            default:          w_take = 1'b0;
         endcase
      end
   end

   assign w_redirect = ex_valid & w_take;

   always_comb begin
      PCSel   = PC_PLUS4;
      InstSel = 1'b0;
      if (!w_run) begin
         PCSel   = PC_HOLD;
         InstSel = 1'b1;
      end else if (w_redirect) begin
         PCSel   = PC_ALU;
         InstSel = 1'b1;
      end else if (stall_req) begin
         PCSel   = PC_HOLD;
         InstSel = 1'b1;
      end
   end

   assign BrUn = ex_valid & r_ex.is_branch & ((r_ex.funct3 == F3_BLTU) | (r_ex.funct3 == F3_BGEU));

   assign FA_2 = ex_valid & r_ex.uses_rs1 & w_run & fwd_hit(r_wb, r_ex.rs1);
   assign FB_2 = ex_valid & r_ex.uses_rs2 & w_run & fwd_hit(r_wb, r_ex.rs2);
   assign FA_1 = w_uses_rs1 & w_run & fwd_hit(r_wb, w_rs1);
   assign FB_1 = w_uses_rs2 & w_run & fwd_hit(r_wb, w_rs2);

   always_comb begin
      w_id           = '0;
      w_id.valid     = ~InstSel;
      w_id.opcode    = inst_id[6:0];
      w_id.funct3    = inst_id[14:12];
      w_id.rd        = w_rd;
      w_id.rs1       = w_rs1;
      w_id.rs2       = w_rs2;
      w_id.regwr     = w_regwr;
      w_id.uses_rs1  = w_uses_rs1;
      w_id.uses_rs2  = w_uses_rs2;
      w_id.is_branch = w_is_branch;
      w_id.is_jump   = w_is_jump;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_BOOT;
         r_ex          <= '0;
         r_wb          <= '0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_state <= ST_RUN;
         r_wb    <= r_ex;
         r_ex    <= w_id;
         if (cnt_clr) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
         end else begin
            if (w_run)    r_cycle_cnt   <= r_cycle_cnt + 1'b1;
            if (wb_valid) r_instret_cnt <= r_instret_cnt + 1'b1;
         end
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;

   // The boot cycle fetches from the reset vector, which must be word aligned.
   always_ff @(posedge clk) begin
      if (rst && r_state == ST_BOOT) assert (RESET_PC[1:0] == 2'b00);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] I1    = 32'h0070_0293; // addi x5,x0,7
   localparam logic [31:0] I2    = 32'h0012_8313; // addi x6,x5,1
   localparam logic [31:0] I3    = 32'h0062_83B3; // add  x7,x5,x6
   localparam logic [31:0] J1    = 32'h0070_0013; // addi x0,x0,7
   localparam logic [31:0] J2    = 32'h0010_0013; // addi x0,x0,1
   localparam logic [31:0] J3    = 32'h0000_0033; // add  x0,x0,x0
   localparam logic [31:0] BNE_I  = 32'h0020_9063;
   localparam logic [31:0] BLTU_I = 32'h0020_E063;
   localparam logic [31:0] BLT_I  = 32'h0020_C063;
   localparam logic [31:0] JAL_I  = 32'h0000_00EF;
   localparam logic [31:0] JALR_I = 32'h0001_00E7;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_id;
   logic        BrEq, BrLt, stall_req, cnt_clr;
   logic [1:0]  PCSel;
   logic        InstSel, BrUn, FA_1, FB_1, FA_2, FB_2, ex_valid, wb_valid;
   logic [31:0] cycle_cnt, instret_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst), .inst_id(inst_id), .BrEq(BrEq), .BrLt(BrLt),
      .stall_req(stall_req), .cnt_clr(cnt_clr), .PCSel(PCSel), .InstSel(InstSel),
      .BrUn(BrUn), .FA_1(FA_1), .FB_1(FB_1), .FA_2(FA_2), .FB_2(FB_2),
      .ex_valid(ex_valid), .wb_valid(wb_valid), .cycle_cnt(cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: instruction words held in EX and WB plus their valid bits.
   bit          m_boot;
   logic [31:0] m_ex_i, m_wb_i;
   bit          m_ex_v, m_wb_v;
   logic [31:0] m_cyc, m_ret;

   logic [1:0]  s_pcsel;
   logic        s_instsel, s_brun, s_fa1, s_fb1, s_fa2, s_fb2, s_exv, s_wbv;

   function automatic bit writes_reg(input logic [31:0] i);
      case (i[6:0])
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
         7'b0000011, 7'b0010011, 7'b0110011: return i[11:7] != 5'd0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit reads_rs1(input logic [31:0] i);
      case (i[6:0])
         7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
         7'b0010011, 7'b0110011: return 1'b1;
         7'b1110011: return i[14:12] == 3'b001;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit reads_rs2(input logic [31:0] i);
      return (i[6:0] == 7'b1100011) || (i[6:0] == 7'b0100011) || (i[6:0] == 7'b0110011);
   endfunction

   function automatic bit taken(input logic [31:0] i, input logic beq, input logic blt);
      if (i[6:0] == 7'b1101111 || i[6:0] == 7'b1100111) return 1'b1;
      if (i[6:0] != 7'b1100011) return 1'b0;
      case (i[14:12])
         3'd0:       return beq;
         3'd1:       return !beq;
         3'd4, 3'd6: return blt;
         3'd5, 3'd7: return !blt;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic bit wb_gives(input bit wbv, input logic [4:0] r);
      return wbv && writes_reg(m_wb_i) && (m_wb_i[11:7] == r);
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [6:0] op;
      case ($urandom_range(0, 10))
         0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
         3: op = 7'b1100111;  4: op = 7'b1100011;  5: op = 7'b0000011;
         6: op = 7'b0100011;  7: op = 7'b0010011;  8: op = 7'b0110011;
         9: op = 7'b1110011;  default: op = 7'b1111111;
      endcase
      return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)), op};
   endfunction

   task automatic step(input logic [31:0] ins, input logic beq, input logic blt,
                       input logic stl, input logic clr, input logic rstn, input bit frc);
      logic [1:0] e_pc;
      logic       e_is, e_exv, e_wbv;
      bit         run;
      @(negedge clk);
      rst = rstn; inst_id = ins; BrEq = beq; BrLt = blt; stall_req = stl; cnt_clr = clr;
      if (frc) begin
         force dut.r_cycle_cnt = 32'hFFFF_FFFF;
         m_cyc = 32'hFFFF_FFFF;
      end
      #1;
      if (frc) release dut.r_cycle_cnt;
      s_pcsel = PCSel; s_instsel = InstSel; s_brun = BrUn;
      s_fa1 = FA_1; s_fb1 = FB_1; s_fa2 = FA_2; s_fb2 = FB_2;
      s_exv = ex_valid; s_wbv = wb_valid;

      run   = rstn && !m_boot;
      e_exv = run && m_ex_v;
      e_wbv = run && m_wb_v;
      if (!run)                                 begin e_pc = 2'b10; e_is = 1'b1; end
      else if (e_exv && taken(m_ex_i, beq, blt)) begin e_pc = 2'b01; e_is = 1'b1; end
      else if (stl)                             begin e_pc = 2'b10; e_is = 1'b1; end
      else                                      begin e_pc = 2'b00; e_is = 1'b0; end

      check_eq("pcsel",   s_pcsel,   e_pc);
      check_eq("instsel", s_instsel, e_is);
      check_eq("brun",    s_brun,    e_exv && m_ex_i[6:0] == 7'b1100011 && m_ex_i[14:13] == 2'b11);
      check_eq("fa2",     s_fa2,     e_exv && reads_rs1(m_ex_i) && wb_gives(e_wbv, m_ex_i[19:15]));
      check_eq("fb2",     s_fb2,     e_exv && reads_rs2(m_ex_i) && wb_gives(e_wbv, m_ex_i[24:20]));
      check_eq("fa1",     s_fa1,     reads_rs1(ins) && wb_gives(e_wbv, ins[19:15]));
      check_eq("fb1",     s_fb1,     reads_rs2(ins) && wb_gives(e_wbv, ins[24:20]));
      check_eq("ex_valid", s_exv,    e_exv);
      check_eq("wb_valid", s_wbv,    e_wbv);
      check_eq("cycle_cnt",   cycle_cnt,   m_cyc);
      check_eq("instret_cnt", instret_cnt, m_ret);

      @(posedge clk);
      if (!rstn) begin
         m_boot = 1'b1; m_ex_v = 1'b0; m_wb_v = 1'b0; m_cyc = '0; m_ret = '0;
      end else begin
         m_wb_i = m_ex_i; m_wb_v = m_ex_v;
         m_ex_i = ins;    m_ex_v = !e_is;
         if (clr) begin
            m_cyc = '0; m_ret = '0;
         end else begin
            if (run)   m_cyc = m_cyc + 1;
            if (e_wbv) m_ret = m_ret + 1;
         end
         m_boot = 1'b0;
      end
      #1;
   endtask

   initial begin
      rst = 1'b0; inst_id = NOP; BrEq = 1'b0; BrLt = 1'b0; stall_req = 1'b0; cnt_clr = 1'b0;
      m_boot = 1'b1; m_ex_i = NOP; m_wb_i = NOP; m_ex_v = 1'b0; m_wb_v = 1'b0;
      m_cyc = '0; m_ret = '0;
      repeat (3) @(posedge clk);

      // reset state, then boot sequence
      step(NOP, 0, 0, 0, 0, 0, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("boot_pcsel", s_pcsel, 2'b10);
      check_eq("boot_instsel", s_instsel, 1'b1);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("run_pcsel", s_pcsel, 2'b00);
      check_eq("run_instsel", s_instsel, 1'b0);
      check_eq("cyc_first", cycle_cnt, 32'd1);

      // RAW chain
      step(I1, 0, 0, 0, 0, 1, 0);
      step(I2, 0, 0, 0, 0, 1, 0);
      step(I3, 0, 0, 0, 0, 1, 0);
      check_eq("raw_fa2", s_fa2, 1'b1);
      check_eq("raw_fa1_id", s_fa1, 1'b1);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("raw_fb2", s_fb2, 1'b1);
      check_eq("raw_fa1_0", s_fa1, 1'b0);

      // same chain targeting x0
      step(J1, 0, 0, 0, 0, 1, 0);
      step(J2, 0, 0, 0, 0, 1, 0);
      step(J3, 0, 0, 0, 0, 1, 0);
      check_eq("x0_fa2", s_fa2, 1'b0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("x0_fa2b", s_fa2, 1'b0);
      check_eq("x0_fb2", s_fb2, 1'b0);

      // BNE taken / not taken
      step(BNE_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("bne_t_pcsel", s_pcsel, 2'b01);
      check_eq("bne_t_instsel", s_instsel, 1'b1);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("bne_t_bubble", s_exv, 1'b0);
      step(BNE_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 1, 0, 0, 0, 1, 0);
      check_eq("bne_n_pcsel", s_pcsel, 2'b00);
      check_eq("bne_n_instsel", s_instsel, 1'b0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("bne_n_exv", s_exv, 1'b1);

      // signedness and unconditional jump
      step(BLTU_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("bltu_brun", s_brun, 1'b1);
      step(BLT_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      check_eq("blt_brun", s_brun, 1'b0);
      step(JAL_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 1, 1, 0, 0, 1, 0);
      check_eq("jal_pcsel", s_pcsel, 2'b01);

      // stall and drain
      step(NOP, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 1, 0, 1, 0);
      check_eq("stall1_pcsel", s_pcsel, 2'b10);
      check_eq("stall1_instsel", s_instsel, 1'b1);
      step(NOP, 0, 0, 1, 0, 1, 0);
      check_eq("stall2_pcsel", s_pcsel, 2'b10);
      check_eq("stall2_instsel", s_instsel, 1'b1);
      step(NOP, 0, 0, 1, 0, 1, 0);
      check_eq("stall_drain_wbv", s_wbv, 1'b0);
      step(JALR_I, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 1, 0, 1, 0);
      check_eq("jalr_stall_pcsel", s_pcsel, 2'b01);

      // counter wrap and clear
      step(NOP, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 0);
      step(NOP, 0, 0, 0, 0, 1, 1);
      check_eq("cyc_wrap", cycle_cnt, 32'd0);
      step(NOP, 0, 0, 0, 1, 1, 0);
      check_eq("clr_wbv", s_wbv, 1'b1);
      check_eq("clr_ret", instret_cnt, 32'd0);
      check_eq("clr_cyc", cycle_cnt, 32'd0);

      // random traffic, including occasional mid-run reset
      for (int k = 0; k < 400; k++) begin
         step(rnd_inst(), 1'($urandom), 1'($urandom),
              $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 99) != 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 3-stage Riscv151 datapath (IF/D, EX, MEM/WB). It decides fetch steering (PCSel), bubble injection (InstSel), branch signedness (BrUn) and all four forwarding selects (FA_1, FB_1, FA_2, FB_2).
- Tracks per-stage instruction records for EX and WB.
- Sequences the post-reset boot cycle.
- Maintains cycle and retired-instruction counters, which the memory-mapped counter registers read.

Parameters:
- RESET_PC, 32'h4000_0000, value of the PC during reset; used only for the boot-cycle assertion check.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge of clk resets the block).
- inst_id  in  32  raw instruction word currently in IF/D, before the InstSel mux.
- BrEq  in  1  branch comparator equal, from the EX stage.
- BrLt  in  1  branch comparator less-than, from the EX stage.
- stall_req  in  1  external fetch-freeze request.
- cnt_clr  in  1  synchronous clear of both counters.
- PCSel  out  2  00 = PC+4, 01 = ALU_out (redirect), 10 = hold PC.
- InstSel  out  1  1 = replace the IF/D instruction with NOP 32'h00000013.
- BrUn  out  1  unsigned compare for the EX branch.
- FA_1  out  1  forward wd into the IF/D rs1 path.
- FB_1  out  1  forward wd into the IF/D rs2 path.
- FA_2  out  1  forward wd into the EX rs1 path.
- FB_2  out  1  forward wd into the EX rs2 path.
- ex_valid  out  1  EX stage holds a real (non-bubble) instruction.
- wb_valid  out  1  MEM/WB stage holds a real instruction.
- cycle_cnt  out  CNT_W  cycles since reset or clear.
- instret_cnt  out  CNT_W  instructions retired from WB.

Behaviour:
- States: BOOT, RUN.
  - rst==0 forces BOOT.
  - BOOT lasts exactly one cycle after rst goes high, then moves to RUN.
- Outputs while in reset and in BOOT: PCSel=10, InstSel=1, FA/FB all 0, BrUn=0, ex_valid=0, wb_valid=0. Counters are held at 0 during reset.
- Stage record fields: {valid, opcode, funct3, rd, rs1, rs2, regwr, uses_rs1, uses_rs2}.
  - Each cycle the EX record moves to WB.
  - The IF/D record moves to EX with valid = !InstSel.
- Decode classes:
  - regwr: LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, with rd != 0.
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM with funct3 = 001.
  - uses_rs2: BRANCH, STORE, OP.
- Redirect in EX (combinational from the EX record, BrEq and BrLt), taken when ex.valid and any of:
  - JAL or JALR;
  - BRANCH with condition true: BEQ → BrEq; BNE → !BrEq; BLT/BLTU → BrLt; BGE/BGEU → !BrLt.
- BrUn = ex.valid & BRANCH & funct3 ∈ {110, 111}.
- RUN priority, highest first:
  - redirect → PCSel=01, InstSel=1. Exactly one bubble; the wrong-path IF/D instruction is killed.
  - stall_req → PCSel=10, InstSel=1. Memory re-reads the same PC, so the held instruction reappears next cycle.
  - otherwise → PCSel=00, InstSel=0.
- Redirect and stall_req in the same cycle: redirect wins and the stall is dropped for that cycle.
- Forwarding (combinational), with match(r) = wb.valid & wb.regwr & wb.rd == r:
  - FA_2 = ex.valid & ex.uses_rs1 & match(ex.rs1); FB_2 likewise for rs2.
  - FA_1 = uses_rs1(inst_id) & match(rs1(inst_id)); FB_1 likewise for rs2. This covers same-cycle regfile write versus read.
  - Load-use needs no stall: WB wd forwards into EX.
  - x0 never forwards.
- Counters:
  - cycle_cnt increments every RUN cycle.
  - instret_cnt increments when wb_valid=1.
  - cnt_clr has priority and sets both counters to 0.
  - Both counters wrap modulo 2^CNT_W.
- Mid-operation reset: all records are invalidated and the block returns to BOOT in the next cycle; no partial redirect survives.
- Unknown opcodes decode as regwr=0, uses_rs1=0, uses_rs2=0, with no redirect.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants: OPC_LUI 0110111, OPC_AUIPC 0010111, OPC_JAL 1101111, OPC_JALR 1100111, OPC_BRANCH 1100011, OPC_LOAD 0000011, OPC_STORE 0100011, OPC_OPIMM 0010011, OPC_OP 0110011, OPC_SYSTEM 1110011;
  - branch funct3 codes;
  - NOP_INST;
  - PCSel encodings PC_PLUS4, PC_ALU, PC_HOLD;
  - the stage-record struct typedef.
- Sub-module hz_decode: inst → {rd, rs1, rs2, regwr, uses_rs1, uses_rs2, is_branch, is_jump}. It is instantiated once for inst_id; the EX record stores its output.

Test Plan:
- Boot: hold rst=0 for 3 cycles, then release. Required: PCSel=10 and InstSel=1 in the first RUN-side cycle, then PCSel=00 and InstSel=0. cycle_cnt=1 after the first RUN cycle.
- RAW chain: addi x5,x0,7; addi x6,x5,1; add x7,x5,x6. Required: FA_2=1 when the second instruction is in EX; FB_2=1 and FA_1=0 for the third instruction in EX. Same sequence using x0 as the destination: all forwards stay 0.
- Taken BNE with BrEq=0 in EX. Required: PCSel=01 and InstSel=1 that cycle; ex_valid=0 the next cycle. Not-taken (BrEq=1): PCSel=00 and no bubble.
- BLTU in EX. Required: BrUn=1. BLT in EX: BrUn=0. JAL: redirect regardless of BrEq/BrLt.
- stall_req=1 for 2 cycles with no redirect. Required: PCSel=10 and InstSel=1 both cycles; instret_cnt stops increasing after the drain. stall_req together with JALR in EX: PCSel=01.
- Counters: preload cycle_cnt to 32'hFFFF_FFFF through a force. Required: it wraps to 0. cnt_clr asserted while wb_valid=1: instret_cnt=0 the next cycle.
